// File: rtl/vc_input_stage.sv
// Multi-VC router input port: per-VC FIFOs, registered XY route, per-VC IDLE/VA/ACTIVE FSM, round-robin SA offer.
// Latency: head written at edge E0 -> va_req after E0+1 -> earliest sa_req after E0+2; FWFT data, credit one cycle after pop.
// Backpressure: upstream is credit-based (one credit per freed slot); downstream holds the offer until sa_grant.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_vc/in_data    incoming flit and its target VC
//   credit_valid/credit_vc    registered credit return, at most one per cycle
//   va_req/va_grant/va_outvc  per-VC VC-allocation request (one-hot port), grant and assigned downstream VC
//   sa_req/sa_port/sa_outvc/sa_data/sa_grant  switch-allocation offer and acceptance
//   err_overflow/err_protocol sticky error flags
module vc_input_stage #(
    parameter int DW       = 64,
    parameter int NUM_VC   = 2,
    parameter int VC_DEPTH = 4,
    parameter int COORD_W  = 4,
    parameter int LOCAL_X  = 0,
    parameter int LOCAL_Y  = 0,
    localparam int VCW     = $clog2(NUM_VC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [VCW-1:0]        in_vc,
    input  logic [DW-1:0]         in_data,
    output logic                  credit_valid,
    output logic [VCW-1:0]        credit_vc,
    output logic [NUM_VC*5-1:0]   va_req,
    input  logic [NUM_VC-1:0]     va_grant,
    input  logic [NUM_VC*VCW-1:0] va_outvc,
    output logic                  sa_req,
    output logic [4:0]            sa_port,
    output logic [VCW-1:0]        sa_outvc,
    output logic [DW-1:0]         sa_data,
    input  logic                  sa_grant,
    output logic                  err_overflow,
    output logic                  err_protocol
);

    localparam int PW = $clog2(VC_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]      DEPTH_C = CW'(VC_DEPTH);
    localparam logic [COORD_W-1:0] LX      = COORD_W'(LOCAL_X);
    localparam logic [COORD_W-1:0] LY      = COORD_W'(LOCAL_Y);

    typedef enum logic [1:0] {
        VC_IDLE   = 2'd0,
        VC_VA     = 2'd1,
        VC_ACTIVE = 2'd2
    } vc_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DW-1:0]  mem_q      [NUM_VC][VC_DEPTH];
    logic [PW-1:0]  rd_ptr_q   [NUM_VC];
    logic [PW-1:0]  rd_ptr_d   [NUM_VC];
    logic [PW-1:0]  wr_ptr_q   [NUM_VC];
    logic [PW-1:0]  wr_ptr_d   [NUM_VC];
    logic [CW-1:0]  count_q    [NUM_VC];
    logic [CW-1:0]  count_d    [NUM_VC];
    vc_state_e      state_q    [NUM_VC];
    vc_state_e      state_d    [NUM_VC];
    logic [4:0]     route_q    [NUM_VC];
    logic [4:0]     route_d    [NUM_VC];
    logic [VCW-1:0] outvc_q    [NUM_VC];
    logic [VCW-1:0] outvc_d    [NUM_VC];
    logic [VCW-1:0] rr_q, rr_d;
    logic           credit_valid_q, credit_valid_d;
    logic [VCW-1:0] credit_vc_q, credit_vc_d;
    logic           err_overflow_q, err_overflow_d;
    logic           err_protocol_q, err_protocol_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [DW-1:0]     front [NUM_VC];
    logic [NUM_VC-1:0] not_empty;
    logic [NUM_VC-1:0] eligible;
    logic [NUM_VC-1:0] needs_discard;
    logic [NUM_VC-1:0] pop;
    logic [NUM_VC-1:0] wr_hit;
    logic              sel_found;
    logic [VCW-1:0]    sel_vc;
    logic [VCW-1:0]    cand;
    logic              disc_found;
    logic [VCW-1:0]    disc_vc;
    logic              sa_pop;
    logic              disc_fire;
    logic              in_vc_ok;
    logic              in_vc_full;
    logic              wr_en;

    // Borrow out of a one-bit-wider subtraction gives the unsigned
    // less-than without a compare that can fold to a constant when the
    // local coordinate is 0.
    function automatic logic [4:0] xy_route(input logic [DW-1:0] f);
        logic [COORD_W:0] ddx;
        logic [COORD_W:0] ddy;
        ddx = {1'b0, f[COORD_W-1:0]} - {1'b0, LX};
        ddy = {1'b0, f[2*COORD_W-1:COORD_W]} - {1'b0, LY};
        if (ddx[COORD_W])               return 5'b00100;  // west
        else if (ddx != '0)             return 5'b00010;  // east
        else if (ddy[COORD_W])          return 5'b10000;  // south
        else if (ddy != '0)             return 5'b01000;  // north
        else                            return 5'b00001;  // local
    endfunction

    // Flit type in the top two bits: bit1 set marks head/single (packet
    // start), bit0 set marks tail/single (packet end).
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            front[v]         = mem_q[v][rd_ptr_q[v]];
            not_empty[v]     = (count_q[v] != '0);
            eligible[v]      = not_empty[v] && (state_q[v] == VC_ACTIVE);
            needs_discard[v] = not_empty[v] && (state_q[v] == VC_IDLE) && !front[v][DW-1];
        end
    end

    // Round-robin: search starts one past the VC served last.
    always_comb begin
        sel_found = 1'b0;
        sel_vc    = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_VC; i++) begin
            cand = VCW'((int'(rr_q) + i) % NUM_VC);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_vc    = cand;
            end
        end
    end

    // Only one stray body/tail can be dropped per cycle, lowest VC first.
    always_comb begin
        disc_found = 1'b0;
        disc_vc    = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (!disc_found && needs_discard[v]) begin
                disc_found = 1'b1;
                disc_vc    = VCW'(v);
            end
        end
    end

    // The credit path carries one credit per cycle, so a discard yields
    // to an SA pop and simply retries next cycle.
    always_comb begin
        sa_pop     = sel_found && sa_grant;
        disc_fire  = disc_found && !sa_pop;
        in_vc_ok   = (int'(in_vc) < NUM_VC);
        pop        = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            pop[v] = (sa_pop && (sel_vc == VCW'(v))) || (disc_fire && (disc_vc == VCW'(v)));
        end
        in_vc_full = in_vc_ok && (count_q[in_vc] == DEPTH_C);
        // A full VC still takes the write when it frees a slot this cycle.
        wr_en      = in_valid && in_vc_ok && (!in_vc_full || pop[in_vc]);
        wr_hit     = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_hit[v] = wr_en && (in_vc == VCW'(v));
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        state_d        = state_q;
        route_d        = route_q;
        outvc_d        = outvc_q;
        rr_d           = rr_q;
        credit_valid_d = 1'b0;
        credit_vc_d    = '0;
        err_overflow_d = err_overflow_q;
        err_protocol_d = err_protocol_q;

        for (int v = 0; v < NUM_VC; v++) begin
            if (pop[v]) begin
                rd_ptr_d[v] = rd_ptr_q[v] + PW'(1);
            end
            if (wr_hit[v]) begin
                wr_ptr_d[v] = wr_ptr_q[v] + PW'(1);
            end
            count_d[v] = count_q[v] + CW'(wr_hit[v]) - CW'(pop[v]);

            case (state_q[v])
                VC_IDLE: begin
                    if (not_empty[v] && front[v][DW-1]) begin
                        route_d[v] = xy_route(front[v]);
                        state_d[v] = VC_VA;
                    end
                end
                VC_VA: begin
                    if (va_grant[v]) begin
                        outvc_d[v] = va_outvc[v*VCW +: VCW];
                        state_d[v] = VC_ACTIVE;
                    end
                end
                VC_ACTIVE: begin
                    if (pop[v] && front[v][DW-2]) begin
                        state_d[v] = VC_IDLE;
                    end
                end
                default: begin
                    state_d[v] = VC_IDLE;
                end
            endcase
        end

        if (sa_pop) begin
            rr_d           = sel_vc;
            credit_valid_d = 1'b1;
            credit_vc_d    = sel_vc;
        end else if (disc_fire) begin
            credit_valid_d = 1'b1;
            credit_vc_d    = disc_vc;
            err_protocol_d = 1'b1;
        end

        if (in_valid && in_vc_ok && in_vc_full && !pop[in_vc]) begin
            err_overflow_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                rd_ptr_q[v] <= '0;
                wr_ptr_q[v] <= '0;
                count_q[v]  <= '0;
                state_q[v]  <= VC_IDLE;
                route_q[v]  <= '0;
                outvc_q[v]  <= '0;
            end
            rr_q           <= VCW'(NUM_VC - 1);
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
            err_overflow_q <= 1'b0;
            err_protocol_q <= 1'b0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            state_q        <= state_d;
            route_q        <= route_d;
            outvc_q        <= outvc_d;
            rr_q           <= rr_d;
            credit_valid_q <= credit_valid_d;
            credit_vc_q    <= credit_vc_d;
            err_overflow_q <= err_overflow_d;
            err_protocol_q <= err_protocol_d;
        end
    end

    // Flit storage needs no reset: contents are only observed through
    // count-qualified reads.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[in_vc][wr_ptr_q[in_vc]] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        va_req = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (state_q[v] == VC_VA) begin
                va_req[v*5 +: 5] = route_q[v];
            end
        end
        sa_req   = sel_found;
        sa_port  = sel_found ? route_q[sel_vc] : 5'b00000;
        sa_outvc = sel_found ? outvc_q[sel_vc] : '0;
        sa_data  = sel_found ? front[sel_vc]   : '0;
    end

    assign credit_valid = credit_valid_q;
    assign credit_vc    = credit_vc_q;
    assign err_overflow = err_overflow_q;
    assign err_protocol = err_protocol_q;

endmodule

// File: tb/tb_vc_input_stage.sv
// Directed bench for vc_input_stage (DW=64, NUM_VC=2, VC_DEPTH=4, local (0,0)).
// Inputs change on the falling edge; outputs are checked on the falling edge.
// Expected values are hand-derived constants per scenario.
module tb_vc_input_stage;

    localparam int DW     = 64;
    localparam int NUM_VC = 2;
    localparam int VCW    = 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic [VCW-1:0]        in_vc;
    logic [DW-1:0]         in_data;
    logic                  credit_valid;
    logic [VCW-1:0]        credit_vc;
    logic [NUM_VC*5-1:0]   va_req;
    logic [NUM_VC-1:0]     va_grant;
    logic [NUM_VC*VCW-1:0] va_outvc;
    logic                  sa_req;
    logic [4:0]            sa_port;
    logic [VCW-1:0]        sa_outvc;
    logic [DW-1:0]         sa_data;
    logic                  sa_grant;
    logic                  err_overflow;
    logic                  err_protocol;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cred   = 0;

    logic [63:0] pa [4];
    logic [63:0] pb [4];
    logic [63:0] e3 [5];
    logic [63:0] f1;
    logic [63:0] f60;

    vc_input_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_vc        (in_vc),
        .in_data      (in_data),
        .credit_valid (credit_valid),
        .credit_vc    (credit_vc),
        .va_req       (va_req),
        .va_grant     (va_grant),
        .va_outvc     (va_outvc),
        .sa_req       (sa_req),
        .sa_port      (sa_port),
        .sa_outvc     (sa_outvc),
        .sa_data      (sa_data),
        .sa_grant     (sa_grant),
        .err_overflow (err_overflow),
        .err_protocol (err_protocol)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] flit(input logic [1:0] t, input logic [7:0] id,
                                         input logic [3:0] x, input logic [3:0] y);
        return {t, 46'd0, id, y, x};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_vc    = '0;
        in_data  = '0;
        va_grant = '0;
        va_outvc = '0;
        sa_grant = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr(input logic vc, input logic [63:0] d);
        in_valid = 1'b1;
        in_vc    = vc;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        chk("rst_sa_req",   64'(sa_req),       64'd0);
        chk("rst_va_req",   64'(va_req),       64'd0);
        chk("rst_credit",   64'(credit_valid), 64'd0);
        chk("rst_sa_data",  sa_data,           64'd0);
        chk("rst_sa_port",  64'(sa_port),      64'd0);
        chk("rst_err_ovf",  64'(err_overflow), 64'd0);
        chk("rst_err_prot", 64'(err_protocol), 64'd0);

        // ---------------- two 4-flit packets, alternating SA ----------------
        for (int i = 0; i < 4; i++) begin
            pa[i] = flit((i == 0) ? 2'b10 : ((i == 3) ? 2'b01 : 2'b00), 8'(i), 4'd0, 4'd3);
            pb[i] = flit((i == 0) ? 2'b10 : ((i == 3) ? 2'b01 : 2'b00), 8'(16 + i), 4'd1, 4'd1);
        end
        va_grant = 2'b11;
        va_outvc = 2'b01;      // VC0 -> outvc 1, VC1 -> outvc 0
        for (int i = 0; i < 4; i++) wr(1'b0, pa[i]);
        for (int i = 0; i < 4; i++) wr(1'b1, pb[i]);
        va_grant = 2'b00;
        chk("alt_va_done", 64'(va_req), 64'd0);
        sa_grant = 1'b1;
        n_cred   = 0;
        for (int k = 0; k < 8; k++) begin
            chk("alt_sa_req",   64'(sa_req), 64'd1);
            chk("alt_sa_data",  sa_data, (k % 2 == 0) ? pa[k/2] : pb[k/2]);
            chk("alt_sa_port",  64'(sa_port), (k % 2 == 0) ? 64'b01000 : 64'b00010);
            chk("alt_sa_outvc", 64'(sa_outvc), (k % 2 == 0) ? 64'd1 : 64'd0);
            if (k > 0) begin
                chk("alt_credit_vld", 64'(credit_valid), 64'd1);
                chk("alt_credit_vc",  64'(credit_vc), 64'((k - 1) % 2));
            end
            if (credit_valid) n_cred++;
            step();
        end
        sa_grant = 1'b0;
        chk("alt_last_credit_vc", 64'(credit_vc), 64'd1);
        if (credit_valid) n_cred++;
        chk("alt_credit_count", 64'(n_cred), 64'd8);
        chk("alt_drained_sa_req", 64'(sa_req), 64'd0);
        step();
        chk("alt_credit_idle", 64'(credit_valid), 64'd0);

        // ---------------- single flit, dest (2,0) ----------------
        do_reset();
        f1 = flit(2'b11, 8'h55, 4'd2, 4'd0);
        wr(1'b0, f1);
        chk("single_va_early", 64'(va_req), 64'd0);
        step();
        chk("single_va_req", 64'(va_req), 64'b00000_00010);
        va_grant = 2'b01;
        va_outvc = 2'b01;
        step();
        va_grant = 2'b00;
        chk("single_sa_req",   64'(sa_req),   64'd1);
        chk("single_sa_port",  64'(sa_port),  64'b00010);
        chk("single_sa_outvc", 64'(sa_outvc), 64'd1);
        chk("single_sa_data",  sa_data,       f1);
        chk("single_va_off",   64'(va_req),   64'd0);
        sa_grant = 1'b1;
        step();
        sa_grant = 1'b0;
        chk("single_credit_vld", 64'(credit_valid), 64'd1);
        chk("single_credit_vc",  64'(credit_vc),    64'd0);
        chk("single_sa_gone",    64'(sa_req),       64'd0);
        step();
        chk("single_credit_one", 64'(credit_valid), 64'd0);
        chk("single_vc0_idle",   64'(va_req),       64'd0);

        // ---------------- overflow on VC1, VC0 unaffected, local route ----------------
        do_reset();
        e3[0] = flit(2'b11, 8'd30, 4'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            e3[i+1] = flit((i == 0) ? 2'b10 : 2'b00, 8'(20 + i), 4'd0, 4'd2);
            wr(1'b1, e3[i+1]);
        end
        chk("ovf_not_yet", 64'(err_overflow), 64'd0);
        chk("ovf_vc1_va",  64'(va_req), 64'b01000_00000);
        wr(1'b1, flit(2'b00, 8'd24, 4'd0, 4'd2));
        chk("ovf_flag", 64'(err_overflow), 64'd1);
        wr(1'b0, e3[0]);
        step();
        chk("ovf_vc0_va", 64'(va_req), 64'b01000_00001);
        va_grant = 2'b01;
        va_outvc = 2'b00;
        step();
        chk("local_sa_req",  64'(sa_req),  64'd1);
        chk("local_sa_port", 64'(sa_port), 64'b00001);
        chk("local_sa_data", sa_data,      e3[0]);
        chk("ovf_no_credit", 64'(credit_valid), 64'd0);
        va_grant = 2'b10;
        va_outvc = 2'b10;
        step();
        va_grant = 2'b00;
        sa_grant = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("ovf_drain_data", sa_data, e3[k]);
            step();
        end
        sa_grant = 1'b0;
        chk("ovf_dropped_absent", 64'(sa_req), 64'd0);
        chk("ovf_sticky", 64'(err_overflow), 64'd1);

        // ---------------- body flit into IDLE VC ----------------
        do_reset();
        wr(1'b0, flit(2'b00, 8'd40, 4'd1, 4'd1));
        chk("prot_pre_credit", 64'(credit_valid), 64'd0);
        chk("prot_pre_err",    64'(err_protocol), 64'd0);
        step();
        chk("prot_credit_vld", 64'(credit_valid), 64'd1);
        chk("prot_credit_vc",  64'(credit_vc),    64'd0);
        chk("prot_err",        64'(err_protocol), 64'd1);
        chk("prot_no_va",      64'(va_req),       64'd0);
        step();
        chk("prot_credit_once", 64'(credit_valid), 64'd0);
        chk("prot_no_sa",       64'(sa_req),       64'd0);
        chk("prot_no_va2",      64'(va_req),       64'd0);

        // ---------------- reset mid-packet ----------------
        do_reset();
        va_grant = 2'b10;
        va_outvc = 2'b10;
        wr(1'b1, flit(2'b10, 8'd50, 4'd3, 4'd0));
        wr(1'b1, flit(2'b00, 8'd51, 4'd3, 4'd0));
        step();
        chk("mid_sa_req", 64'(sa_req), 64'd1);
        rst      = 1'b1;
        va_grant = 2'b00;
        #1;
        chk("mid_rst_sa_req",  64'(sa_req),       64'd0);
        chk("mid_rst_sa_data", sa_data,           64'd0);
        chk("mid_rst_va_req",  64'(va_req),       64'd0);
        chk("mid_rst_credit",  64'(credit_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        chk("mid_post_sa_req", 64'(sa_req),       64'd0);
        chk("mid_post_credit", 64'(credit_valid), 64'd0);
        chk("mid_post_va_req", 64'(va_req),       64'd0);
        f60 = flit(2'b11, 8'd60, 4'd0, 4'd0);
        wr(1'b1, f60);
        step();
        chk("mid_new_va", 64'(va_req), 64'b00001_00000);
        va_grant = 2'b10;
        va_outvc = 2'b10;
        step();
        va_grant = 2'b00;
        chk("mid_new_data",  sa_data,        f60);
        chk("mid_new_outvc", 64'(sa_outvc),  64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
